// File: rtl/stim_sequencer.sv
// Operand-pair stimulus sequencer: seeds a 32-bit Galois LFSR, steps it twice per
// vector and presents (A,B) on a valid/ready handshake until the requested count is accepted.
module stim_sequencer #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [31:0]      i_seed,
   input  logic [CNT_W-1:0] i_count,
   output logic [31:0]      o_a,
   output logic [31:0]      o_b,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [CNT_W-1:0] o_vec_idx,
   output logic             o_busy,
   output logic             o_done
);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StGenA,
      StGenB,
      StPresent,
      StDone
   } state_t;

   state_t           state;
   logic [31:0]      lfsr;
   logic [31:0]      lfsr_next;
   logic [CNT_W-1:0] target;
   logic [CNT_W-1:0] idx_inc;
   logic             handshake;

   // Galois step, taps 32,30,26,25: feedback bit r[0] enters at 31 and flips 29,25,24.
   function automatic logic [31:0] lfsr_step(input logic [31:0] r);
      logic [31:0] n;
      n     = {1'b0, r[31:1]};
      n[31] = r[0];
      n[29] = r[30] ^ r[0];
      n[25] = r[26] ^ r[0];
      n[24] = r[25] ^ r[0];
      return n;
   endfunction

   assign lfsr_next = lfsr_step(lfsr);
   assign idx_inc   = o_vec_idx + CNT_W'(1);
   assign handshake = o_valid & i_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= StIdle;
         lfsr      <= 32'h1;
         target    <= '0;
         o_a       <= '0;
         o_b       <= '0;
         o_valid   <= 1'b0;
         o_vec_idx <= '0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
      end else if (i_abort) begin
         // Abort outranks start and handshake; the index is kept for post-mortem.
         state   <= StIdle;
         o_valid <= 1'b0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
      end else begin
         unique case (state)
            StIdle, StDone: begin
               if (i_start) begin
                  lfsr      <= (i_seed == 32'h0) ? 32'h1 : i_seed;
                  target    <= i_count;
                  o_vec_idx <= '0;
                  if (i_count == '0) begin
                     state  <= StDone;
                     o_done <= 1'b1;
                     o_busy <= 1'b0;
                  end else begin
                     state  <= StLoad;
                     o_done <= 1'b0;
                     o_busy <= 1'b1;
                  end
               end
            end
            StLoad: begin
               state <= StGenA;
            end
            StGenA: begin
               lfsr  <= lfsr_next;
               o_a   <= lfsr_next;
               state <= StGenB;
            end
            StGenB: begin
               lfsr    <= lfsr_next;
               o_b     <= lfsr_next;
               o_valid <= 1'b1;
               state   <= StPresent;
            end
            StPresent: begin
               if (handshake) begin
                  o_valid   <= 1'b0;
                  o_vec_idx <= idx_inc;
                  if (idx_inc == target) begin
                     state  <= StDone;
                     o_done <= 1'b1;
                     o_busy <= 1'b0;
                  end else begin
                     state <= StGenA;
                  end
               end
            end
            default: begin
               state   <= StIdle;
               o_valid <= 1'b0;
               o_busy  <= 1'b0;
               o_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stim_sequencer.sv
// Directed, table-driven bench for stim_sequencer: run table plus hand sequences for
// stall, abort, start-while-busy and asynchronous reset.
module tb_stim_sequencer;

   localparam int unsigned CNT_W = 16;

   logic             clk;
   logic             reset;
   logic             i_start;
   logic             i_abort;
   logic [31:0]      i_seed;
   logic [CNT_W-1:0] i_count;
   logic [31:0]      o_a;
   logic [31:0]      o_b;
   logic             o_valid;
   logic             i_ready;
   logic [CNT_W-1:0] o_vec_idx;
   logic             o_busy;
   logic             o_done;

   int n_cmp;
   int n_bad;

   stim_sequencer #(.CNT_W(CNT_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .i_start  (i_start),
      .i_abort  (i_abort),
      .i_seed   (i_seed),
      .i_count  (i_count),
      .o_a      (o_a),
      .o_b      (o_b),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_vec_idx(o_vec_idx),
      .o_busy   (o_busy),
      .o_done   (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]      seed;
      logic [CNT_W-1:0] count;
      logic [31:0]      exp_a;
      logic [31:0]      exp_b;
   } vec_t;

   vec_t tbl[5];

   function automatic logic [31:0] model_step(input logic [31:0] r);
      logic [31:0] n;
      for (int i = 0; i < 31; i++) n[i] = r[i+1];
      n[31] = r[0];
      n[29] = r[30] ^ r[0];
      n[25] = r[26] ^ r[0];
      n[24] = r[25] ^ r[0];
      return n;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the start edge.
   task automatic start_run(input logic [31:0] seed, input logic [CNT_W-1:0] count);
      i_seed  = seed;
      i_count = count;
      i_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_start = 1'b0;
   endtask

   task automatic wait_valid(input int exp_cycles, input string name);
      int n;
      n = 0;
      while (!o_valid && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(n), 32'(exp_cycles));
   endtask

   task automatic handshake();
      i_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_ready = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input string name);
      logic [31:0] m, a, b;
      int          saw_valid;
      start_run(v.seed, v.count);
      m = (v.seed == 32'h0) ? 32'h1 : v.seed;
      if (v.count == '0) begin
         chk({name, " zero done"}, 32'(o_done), 32'd1);
         chk({name, " zero busy"}, 32'(o_busy), 32'd0);
         chk({name, " zero idx"}, 32'(o_vec_idx), 32'd0);
         saw_valid = 0;
         for (int i = 0; i < 4; i++) begin
            if (o_valid) saw_valid = 1;
            @(negedge clk);
         end
         chk({name, " zero never valid"}, 32'(saw_valid), 32'd0);
         return;
      end
      chk({name, " busy after start"}, 32'(o_busy), 32'd1);
      chk({name, " done cleared"}, 32'(o_done), 32'd0);
      chk({name, " idx cleared"}, 32'(o_vec_idx), 32'd0);
      wait_valid(3, {name, " start latency"});
      for (int k = 0; k < int'(v.count); k++) begin
         a = model_step(m);
         b = model_step(a);
         m = b;
         if (k == 0) begin
            chk({name, " first A"}, o_a, v.exp_a);
            chk({name, " first B"}, o_b, v.exp_b);
         end else begin
            chk({name, " A"}, o_a, a);
            chk({name, " B"}, o_b, b);
         end
         handshake();
         chk({name, " idx"}, 32'(o_vec_idx), 32'(k + 1));
         if (k < int'(v.count) - 1) wait_valid(2, {name, " gap"});
      end
      chk({name, " done"}, 32'(o_done), 32'd1);
      chk({name, " busy end"}, 32'(o_busy), 32'd0);
      chk({name, " valid end"}, 32'(o_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a2, b2;
      n_cmp   = 0;
      n_bad   = 0;
      reset   = 1'b1;
      i_start = 1'b0;
      i_abort = 1'b0;
      i_ready = 1'b0;
      i_seed  = '0;
      i_count = '0;

      tbl[0] = '{seed: 32'h0000_0001, count: 16'd2, exp_a: 32'hA300_0000, exp_b: 32'h5180_0000};
      tbl[1] = '{seed: 32'h0000_0000, count: 16'd1, exp_a: 32'hA300_0000, exp_b: 32'h5180_0000};
      tbl[2] = '{seed: 32'h8000_0000, count: 16'd2, exp_a: 32'h4000_0000, exp_b: 32'h2000_0000};
      tbl[3] = '{seed: 32'h0000_0002, count: 16'd3, exp_a: 32'h0000_0001, exp_b: 32'hA300_0000};
      tbl[4] = '{seed: 32'h0000_0001, count: 16'd0, exp_a: 32'h0, exp_b: 32'h0};

      repeat (2) @(negedge clk);
      chk("reset o_a", o_a, 32'h0);
      chk("reset o_b", o_b, 32'h0);
      chk("reset valid", 32'(o_valid), 32'd0);
      chk("reset idx", 32'(o_vec_idx), 32'd0);
      chk("reset busy", 32'(o_busy), 32'd0);
      chk("reset done", 32'(o_done), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Back-to-back runs also exercise restart from DONE.
      for (int t = 0; t < 5; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

      // Stall on vector 2: outputs must hold while ready is low.
      start_run(32'h1, 16'd3);
      wait_valid(3, "stall start latency");
      handshake();
      wait_valid(2, "stall gap1");
      a2 = model_step(32'h5180_0000);
      b2 = model_step(a2);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall A hold", o_a, a2);
         chk("stall B hold", o_b, b2);
         chk("stall valid hold", 32'(o_valid), 32'd1);
      end
      chk("stall idx", 32'(o_vec_idx), 32'd1);
      handshake();
      chk("stall idx2", 32'(o_vec_idx), 32'd2);
      wait_valid(2, "stall gap2");
      handshake();
      chk("stall idx3", 32'(o_vec_idx), 32'd3);
      chk("stall done", 32'(o_done), 32'd1);

      // Abort coincident with handshake: not counted, back to IDLE.
      start_run(32'h1, 16'd3);
      wait_valid(3, "abort start latency");
      handshake();
      wait_valid(2, "abort gap");
      i_ready = 1'b1;
      i_abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_ready = 1'b0;
      i_abort = 1'b0;
      chk("abort valid", 32'(o_valid), 32'd0);
      chk("abort busy", 32'(o_busy), 32'd0);
      chk("abort done", 32'(o_done), 32'd0);
      chk("abort idx held", 32'(o_vec_idx), 32'd1);
      repeat (3) @(negedge clk);
      chk("abort stays idle", 32'(o_busy), 32'd0);
      chk("abort idx still", 32'(o_vec_idx), 32'd1);

      // Abort and start together in IDLE: start dropped.
      i_seed  = 32'h1;
      i_count = 16'd1;
      i_start = 1'b1;
      i_abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_start = 1'b0;
      i_abort = 1'b0;
      chk("abort+start busy", 32'(o_busy), 32'd0);
      repeat (4) @(negedge clk);
      chk("abort+start no valid", 32'(o_valid), 32'd0);

      // Start while busy is ignored: seed and target keep the first request.
      start_run(32'h1, 16'd2);
      i_seed  = 32'h8000_0000;
      i_count = 16'd1;
      i_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_start = 1'b0;
      wait_valid(2, "busy-start latency");
      chk("busy-start A", o_a, 32'hA300_0000);
      handshake();
      chk("busy-start not done", 32'(o_done), 32'd0);
      wait_valid(2, "busy-start gap");
      handshake();
      chk("busy-start done", 32'(o_done), 32'd1);
      chk("busy-start idx", 32'(o_vec_idx), 32'd2);

      // Asynchronous reset while in GEN_B.
      start_run(32'h8000_0000, 16'd2);
      @(negedge clk);
      @(negedge clk);
      chk("pre-reset A", o_a, 32'h4000_0000);
      #2 reset = 1'b1;
      #1;
      chk("async reset A", o_a, 32'h0);
      chk("async reset B", o_b, 32'h0);
      chk("async reset valid", 32'(o_valid), 32'd0);
      chk("async reset busy", 32'(o_busy), 32'd0);
      chk("async reset idx", 32'(o_vec_idx), 32'd0);
      chk("async reset done", 32'(o_done), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_vec(tbl[0], "post-reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
